// File: rtl/if_fetch_unit.sv
// IF-stage fetch unit: issues the current pc to instruction memory, buffers the
// in-order responses for decode, and discards stale fetches after a redirect.
module if_fetch_unit #(
   parameter int          DEPTH  = 2,
   parameter logic [31:0] RST_PC = 32'h0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc_in,
   output logic        pc_load,
   input  logic        redirect,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] fq_wr_q, fq_wr_d, fq_rd_q, fq_rd_d;
   logic [PW-1:0] bf_wr_q, bf_wr_d, bf_rd_q, bf_rd_d;
   logic          rst_dly_q;

   logic [31:0]   fq_pc_q    [DEPTH];
   logic [31:0]   bf_instr_q [DEPTH];
   logic [31:0]   bf_pc_q    [DEPTH];

   logic blocked, redir, credit, req_fire, rsp_ok, rsp_drop, rsp_push, id_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Requests and pc loads stay quiet during reset and the cycle after it.
   assign blocked        = reset | rst_dly_q;
   assign redir          = redirect & ~blocked;
   assign credit         = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW+1)'(DEPTH);
   assign imem_req_valid = credit & ~redirect & ~blocked;
   assign imem_req_addr  = pc_in;
   assign req_fire       = imem_req_valid & imem_req_ready;
   assign pc_load        = req_fire | redir;

   // A response with nothing outstanding is ignored so counters never underflow.
   assign rsp_ok   = imem_rsp_valid & (outstanding_q != '0) & ~reset;
   assign rsp_drop = rsp_ok & (redir | (drop_cnt_q != '0));
   assign rsp_push = rsp_ok & ~rsp_drop;

   assign id_valid = (count_q != '0) & ~reset;
   assign id_pop   = id_valid & id_ready;
   assign id_instr = bf_instr_q[bf_rd_q];
   assign id_pc    = id_valid ? bf_pc_q[bf_rd_q] : RST_PC;

   always_comb begin
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
      fq_wr_d       = req_fire ? ptr_inc(fq_wr_q) : fq_wr_q;
      fq_rd_d       = rsp_ok   ? ptr_inc(fq_rd_q) : fq_rd_q;
      drop_cnt_d    = drop_cnt_q;
      count_d       = count_q;
      bf_wr_d       = bf_wr_q;
      bf_rd_d       = bf_rd_q;
      if (redir) begin
         // Everything still in flight is wrong-path; so is a response arriving now.
         drop_cnt_d = outstanding_q - CW'(rsp_ok);
         count_d    = '0;
         bf_wr_d    = '0;
         bf_rd_d    = '0;
      end else begin
         if (rsp_drop) drop_cnt_d = drop_cnt_q - 1'b1;
         count_d = count_q + CW'(rsp_push) - CW'(id_pop);
         if (rsp_push) bf_wr_d = ptr_inc(bf_wr_q);
         if (id_pop)   bf_rd_d = ptr_inc(bf_rd_q);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         count_q       <= '0;
         fq_wr_q       <= '0;
         fq_rd_q       <= '0;
         bf_wr_q       <= '0;
         bf_rd_q       <= '0;
         rst_dly_q     <= 1'b1;
      end else begin
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         count_q       <= count_d;
         fq_wr_q       <= fq_wr_d;
         fq_rd_q       <= fq_rd_d;
         bf_wr_q       <= bf_wr_d;
         bf_rd_q       <= bf_rd_d;
         rst_dly_q     <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (req_fire) fq_pc_q[fq_wr_q] <= pc_in;
      if (rsp_push) begin
         bf_instr_q[bf_wr_q] <= imem_rsp_data;
         bf_pc_q[bf_wr_q]    <= fq_pc_q[fq_rd_q];
      end
   end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: PC register and memory environment plus a queue-based
// reference model of requests in flight and instructions awaiting decode.
module tb_if_fetch_unit;
   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0;

   logic        clock = 1'b0;
   logic        reset, pc_load, redirect, imem_req_valid, imem_req_ready;
   logic        imem_rsp_valid, id_valid, id_ready;
   logic [31:0] pc_in, imem_req_addr, imem_rsp_data, id_instr, id_pc;

   always #5 clock = ~clock;

   if_fetch_unit #(.DEPTH(DEPTH), .RST_PC(RST_PC)) dut (
      .clock(clock), .reset(reset), .pc_in(pc_in), .pc_load(pc_load),
      .redirect(redirect), .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } mreq_t;

   mreq_t       memq[$];   // accepted requests awaiting a response, oldest first
   logic [31:0] bufq[$];   // pcs of instructions waiting for decode, oldest first
   logic [31:0] pc_m, first_tgt;
   int          cyc, lat, n_chk, n_err, n_fires, n_loads, f0, l0;
   bit          known, after_rst, want_first;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'h9E37_79B9;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input bit rst, input bit rdy, input bit idr, input bit redir,
                        input logic [31:0] tgt, input bit allow, input bit spur);
      bit    real_rsp, e_req, e_fire, e_load, e_idv;
      int    stale_n;
      mreq_t h;
      real_rsp = !rst && allow && memq.size() > 0 && memq[0].due <= cyc;
      reset          = rst;
      imem_req_ready = rdy;
      id_ready       = idr;
      redirect       = redir && !rst;
      imem_rsp_valid = real_rsp || (!rst && spur && memq.size() == 0);
      imem_rsp_data  = real_rsp ? instr_of(memq[0].addr) : $urandom;
      pc_in          = pc_m;
      e_req  = !rst && !after_rst && !redir && (memq.size() + bufq.size() < DEPTH);
      e_fire = e_req && rdy;
      e_load = !rst && !after_rst && (e_fire || redir);
      e_idv  = !rst && bufq.size() != 0;
      @(negedge clock);
      if (known) begin
         chk("req_valid", imem_req_valid, e_req);
         chk("req_addr", imem_req_addr, pc_m);
         chk("pc_load", pc_load, e_load);
         chk("id_valid", id_valid, e_idv);
         if (e_idv) begin
            chk("id_pc", id_pc, bufq[0]);
            chk("id_instr", id_instr, instr_of(bufq[0]));
            if (idr && want_first) begin
               chk("first_pc_after_redirect", id_pc, first_tgt);
               want_first = 1'b0;
            end
         end
         stale_n = 0;
         foreach (memq[i]) if (memq[i].stale) stale_n++;
         chk("outstanding", dut.outstanding_q, memq.size());
         chk("drop_cnt", dut.drop_cnt_q, stale_n);
         chk("count", dut.count_q, bufq.size());
      end
      if (imem_req_valid && imem_req_ready) n_fires++;
      if (pc_load) n_loads++;
      @(posedge clock);
      #1;
      if (rst) begin
         memq.delete();
         bufq.delete();
         pc_m       = RST_PC;
         after_rst  = 1'b1;
         known      = 1'b1;
         want_first = 1'b0;
      end else begin
         after_rst = 1'b0;
         if (e_idv && idr) void'(bufq.pop_front());
         if (real_rsp) begin
            h = memq.pop_front();
            if (!redir && !h.stale) bufq.push_back(h.addr);
         end
         if (redir) begin
            bufq.delete();
            foreach (memq[i]) memq[i].stale = 1'b1;
            want_first = 1'b1;
            first_tgt  = tgt;
         end
         if (e_fire) begin
            h.addr  = pc_m;
            h.due   = cyc + lat;
            h.stale = 1'b0;
            memq.push_back(h);
         end
         if (e_load) pc_m = redir ? tgt : pc_m + 32'd4;
      end
      cyc++;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && (memq.size() != 0 || bufq.size() != 0); i++)
         cycle(0, 0, 1, 0, 0, 1, 0);
      chk("drain_idle", dut.outstanding_q + dut.count_q, 0);
   endtask

   initial begin
      reset = 1'b1; redirect = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
      imem_rsp_data = '0; id_ready = 1'b0; pc_in = RST_PC; pc_m = RST_PC;
      cyc = 0; lat = 1; n_chk = 0; n_err = 0; n_fires = 0; n_loads = 0;
      known = 1'b0; after_rst = 1'b0; want_first = 1'b0; first_tgt = '0;

      repeat (2) cycle(1, 0, 0, 0, 0, 0, 0);

      // streaming fetch with single-cycle memory
      lat = 1;
      repeat (20) cycle(0, 1, 1, 0, 0, 1, 0);

      // decode stalled: credit limits issue to DEPTH, then drain and resume
      drain();
      f0 = n_fires;
      repeat (10) cycle(0, 1, 0, 0, 0, 1, 0);
      chk("stall_issue_count", n_fires - f0, DEPTH);
      repeat (10) cycle(0, 1, 1, 0, 0, 1, 0);

      // two requests in flight, redirect to 0x100
      drain();
      lat = 3;
      for (int i = 0; i < 20 && memq.size() < 2; i++) cycle(0, 1, 1, 0, 0, 0, 0);
      chk("two_in_flight", dut.outstanding_q, 2);
      cycle(0, 1, 1, 1, 32'h100, 0, 0);
      lat = 1;
      repeat (15) cycle(0, 1, 1, 0, 0, 1, 0);

      // redirect coinciding with a response
      drain();
      lat = 2;
      for (int i = 0; i < 20 && !(memq.size() == 2 && memq[0].due <= cyc); i++)
         cycle(0, 1, 1, 0, 0, 0, 0);
      cycle(0, 1, 1, 1, 32'h200, 1, 0);
      chk("drop_after_rsp_redirect", dut.drop_cnt_q, 1);
      chk("outstanding_after_redirect", dut.outstanding_q, 1);
      repeat (12) cycle(0, 1, 1, 0, 0, 1, 0);

      // spurious response with nothing outstanding, then memory not ready
      drain();
      cycle(0, 0, 1, 0, 0, 0, 1);
      l0 = n_loads;
      repeat (5) cycle(0, 0, 1, 0, 0, 1, 0);
      chk("no_load_while_not_ready", n_loads - l0, 0);
      cycle(0, 1, 1, 0, 0, 1, 0);
      chk("single_load_on_handshake", n_loads - l0, 1);
      repeat (4) cycle(0, 1, 1, 0, 0, 1, 0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         lat = $urandom_range(1, 3);
         cycle(0, ($urandom % 4) != 0, ($urandom % 3) != 0,
               !after_rst && (($urandom % 16) == 0), $urandom & 32'hFFFF_FFFC,
               ($urandom % 4) != 0, ($urandom % 8) == 0);
      end

      // reset while busy
      lat = 3;
      repeat (6) cycle(0, 1, 0, 0, 0, 1, 0);
      cycle(1, 1, 1, 0, 0, 1, 0);
      chk("rst_outstanding", dut.outstanding_q, 0);
      chk("rst_drop_cnt", dut.drop_cnt_q, 0);
      chk("rst_count", dut.count_q, 0);
      cycle(0, 1, 1, 0, 0, 1, 0);
      lat = 1;
      repeat (10) cycle(0, 1, 1, 0, 0, 1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
